// File: rtl/mz_sched_pkg.sv
// mz_sched_pkg: shared types for the memory-zero scheduler.
//   sched_state_t : scheduler FSM states
//   grant_t       : which requester last owned the mz port
//   zero_req_t    : one queued zero-range request {low, high}
// MZ_ADDRWIDTH fixes the width of the request fields. The scheduler's
// ADDRWIDTH parameter must match it.
package mz_sched_pkg;

    localparam int MZ_ADDRWIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LD_HIGH   = 3'd1,
        ST_LD_LOW    = 3'd2,
        ST_START     = 3'd3,
        ST_GUARD     = 3'd4,
        ST_WAIT_DONE = 3'd5
    } sched_state_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_ZERO  = 1'b1
    } grant_t;

    typedef struct packed {
        logic [MZ_ADDRWIDTH-1:0] low;
        logic [MZ_ADDRWIDTH-1:0] high;
    } zero_req_t;

endpackage

// File: rtl/mz_req_fifo.sv
// mz_req_fifo: synchronous FIFO of zero-range requests.
//   clock, reset      : clock, async active-low reset (empties the FIFO)
//   push, push_data   : write one entry (ignored when full)
//   pop, pop_data     : pop_data shows the head; pop advances it (ignored when empty)
//   full, empty, count: occupancy, all registered-state derived
module mz_req_fifo
    import mz_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  zero_req_t                push_data,
    input  logic                     pop,
    output zero_req_t                pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    zero_req_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mz_zero_scheduler.sv
// mz_zero_scheduler: owns the single control/address port of the mz block.
// Queues zero-range requests and plays each one out as ld_high, ld_low,
// zero, then waits for mz_busy to drop. Host writes share the port with
// round-robin arbitration in IDLE; rd_addr is forwarded whenever the port
// is otherwise unused.
//   clock/reset          : clock, async active-low reset (also resets mz)
//   req_*                : zero-range request handshake, q_count occupancy
//   wr_*                 : host write handshake (stalls, never dropped)
//   rd_addr              : host read address
//   mz_*                 : mz control/address/data port, mz_busy back
//   busy/zero_done/req_err: status
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | port free: arbitrate host write vs queued zero job
// ST_LD_HIGH   | drive job_high with mz_ld_high
// ST_LD_LOW    | drive job_low with mz_ld_low
// ST_START     | pulse mz_zero
// ST_GUARD     | one cycle with mz_busy ignored (mz busy rise latency)
// ST_WAIT_DONE | hold until mz_busy clears, then pulse zero_done
module mz_zero_scheduler
    import mz_sched_pkg::*;
#(
    parameter int ADDRWIDTH = MZ_ADDRWIDTH,
    parameter int DATAWIDTH = 8,
    parameter int QDEPTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRWIDTH-1:0]    req_low,
    input  logic [ADDRWIDTH-1:0]    req_high,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDRWIDTH-1:0]    wr_addr,
    input  logic [DATAWIDTH-1:0]    wr_data,
    input  logic [ADDRWIDTH-1:0]    rd_addr,
    output logic                    mz_ld_high,
    output logic                    mz_ld_low,
    output logic                    mz_zero,
    output logic                    mz_write,
    output logic [ADDRWIDTH-1:0]    mz_addr,
    output logic [DATAWIDTH-1:0]    mz_din,
    input  logic                    mz_busy,
    output logic                    busy,
    output logic                    zero_done,
    output logic                    req_err,
    output logic [$clog2(QDEPTH):0] q_count
);

    sched_state_t           state_q, state_d;
    grant_t                 last_grant_q, last_grant_d;
    logic [ADDRWIDTH-1:0]   job_low_q, job_low_d;
    logic [ADDRWIDTH-1:0]   job_high_q, job_high_d;
    logic                   zero_done_q, zero_done_d;
    logic                   req_err_q, req_err_d;

    zero_req_t              push_req, head;
    logic                   fifo_full, fifo_empty;
    logic                   req_accept, req_push;
    logic                   grant_wr, grant_zero;

    // Gated by reset so every handshake output reads 0 while reset is held.
    assign req_ready  = reset && !fifo_full;
    assign req_accept = req_valid && req_ready;
    assign req_push   = req_accept && (req_low <= req_high);
    assign push_req   = '{low: req_low, high: req_high};

    mz_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (req_push),
        .push_data (push_req),
        .pop       (grant_zero),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (q_count)
    );

    always_comb begin
        grant_wr   = 1'b0;
        grant_zero = 1'b0;
        if (reset && state_q == ST_IDLE) begin
            if (wr_valid && !fifo_empty) begin
                if (last_grant_q == GRANT_WRITE) grant_zero = 1'b1;
                else                             grant_wr   = 1'b1;
            end else if (wr_valid) begin
                grant_wr = 1'b1;
            end else if (!fifo_empty) begin
                grant_zero = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        job_low_d    = job_low_q;
        job_high_d   = job_high_q;
        zero_done_d  = 1'b0;
        req_err_d    = req_accept && (req_low > req_high);
        case (state_q)
            ST_IDLE: begin
                if (grant_zero) begin
                    state_d      = ST_LD_HIGH;
                    job_low_d    = head.low;
                    job_high_d   = head.high;
                    last_grant_d = GRANT_ZERO;
                end else if (grant_wr) begin
                    last_grant_d = GRANT_WRITE;
                end
            end
            ST_LD_HIGH:   state_d = ST_LD_LOW;
            ST_LD_LOW:    state_d = ST_START;
            ST_START:     state_d = ST_GUARD;
            ST_GUARD:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (!mz_busy) begin
                    state_d     = ST_IDLE;
                    zero_done_d = 1'b1;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_ZERO;
            job_low_q    <= '0;
            job_high_q   <= '0;
            zero_done_q  <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            job_low_q    <= job_low_d;
            job_high_q   <= job_high_d;
            zero_done_q  <= zero_done_d;
            req_err_q    <= req_err_d;
        end
    end

    always_comb begin
        mz_ld_high = (state_q == ST_LD_HIGH);
        mz_ld_low  = (state_q == ST_LD_LOW);
        mz_zero    = (state_q == ST_START);
        mz_write   = grant_wr;
        wr_ready   = grant_wr;
        mz_addr    = rd_addr;
        mz_din     = '0;
        if (grant_wr) begin
            mz_addr = wr_addr;
            mz_din  = wr_data;
        end else if (state_q == ST_LD_HIGH) begin
            mz_addr = job_high_q;
        end else if (state_q == ST_LD_LOW) begin
            mz_addr = job_low_q;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign zero_done = zero_done_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_mz_zero_scheduler.sv
// Bench for mz_zero_scheduler: directed scenarios plus a random phase.
// A negedge monitor predicts every output from a job queue, a per-job
// cycle index and a round-robin flag; a small mz model supplies mz_busy.
module tb_mz_zero_scheduler;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int QD = 4;

    logic          clock;
    logic          reset;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_low, req_high;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          mz_ld_high, mz_ld_low, mz_zero, mz_write;
    logic [AW-1:0] mz_addr;
    logic [DW-1:0] mz_din;
    logic          mz_busy;
    logic          busy, zero_done, req_err;
    logic [2:0]    q_count;

    mz_zero_scheduler #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .QDEPTH(QD)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_low    (req_low),
        .req_high   (req_high),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .mz_ld_high (mz_ld_high),
        .mz_ld_low  (mz_ld_low),
        .mz_zero    (mz_zero),
        .mz_write   (mz_write),
        .mz_addr    (mz_addr),
        .mz_din     (mz_din),
        .mz_busy    (mz_busy),
        .busy       (busy),
        .zero_done  (zero_done),
        .req_err    (req_err),
        .q_count    (q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // mz model: latches the range, stays busy for (high-low+1) cycles,
    // with the rise delayed by 0 or 1 cycle at random.
    logic [AW-1:0] mzm_hi, mzm_lo;
    logic [8:0]    mzm_cnt;
    logic          mzm_dly;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mzm_hi  <= '0;
            mzm_lo  <= '0;
            mzm_cnt <= '0;
            mzm_dly <= 1'b0;
        end else begin
            if (mz_ld_high) mzm_hi <= mz_addr;
            if (mz_ld_low)  mzm_lo <= mz_addr;
            if (mz_zero) begin
                mzm_cnt <= 9'(mzm_hi) - 9'(mzm_lo) + 9'd1;
                mzm_dly <= 1'($urandom_range(0, 1));
            end else if (mzm_dly) begin
                mzm_dly <= 1'b0;
            end else if (mzm_cnt != 0) begin
                mzm_cnt <= mzm_cnt - 9'd1;
            end
        end
    end
    assign mz_busy = !mzm_dly && (mzm_cnt != 0);

    // Reference model state.
    typedef struct {
        logic [AW-1:0] low;
        logic [AW-1:0] high;
    } job_t;
    job_t          jobq[$];
    job_t          cur;
    logic          in_job   = 1'b0;
    int            k        = 0;
    logic          exp_done = 1'b0;
    logic          exp_err  = 1'b0;
    logic          last_wr  = 1'b0;
    logic          gw, gz;
    int            qsz;
    logic [AW-1:0] exp_addr;
    int            done_cnt = 0;
    int            acc_cnt  = 0;
    int            err_cnt  = 0;
    int            wr_cnt   = 0;

    always @(negedge clock) begin
        if (!reset) begin
            check_val("rst_flags", {busy, zero_done, req_err, req_ready, wr_ready,
                                    mz_ld_high, mz_ld_low, mz_zero, mz_write}, 0);
            check_val("rst_addr", mz_addr, rd_addr);
            check_val("rst_din", mz_din, 0);
            check_val("rst_qcnt", q_count, 0);
            jobq.delete();
            in_job   = 1'b0;
            k        = 0;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            last_wr  = 1'b0;
        end else begin
            qsz = jobq.size();
            check_val("q_count", q_count, qsz);
            check_val("req_ready", req_ready, qsz < QD);
            check_val("busy", busy, in_job);
            check_val("zero_done", zero_done, exp_done);
            check_val("req_err", req_err, exp_err);
            exp_done = 1'b0;
            exp_err  = 1'b0;
            gw = 1'b0;
            gz = 1'b0;
            if (!in_job) begin
                if (wr_valid && qsz > 0) begin
                    if (last_wr) gz = 1'b1;
                    else         gw = 1'b1;
                end else if (wr_valid) begin
                    gw = 1'b1;
                end else if (qsz > 0) begin
                    gz = 1'b1;
                end
            end
            check_val("wr_ready", wr_ready, gw);
            check_val("mz_write", mz_write, gw);
            check_val("mz_ld_high", mz_ld_high, in_job && k == 0);
            check_val("mz_ld_low", mz_ld_low, in_job && k == 1);
            check_val("mz_zero", mz_zero, in_job && k == 2);
            if (gw)                       exp_addr = wr_addr;
            else if (in_job && k == 0)    exp_addr = cur.high;
            else if (in_job && k == 1)    exp_addr = cur.low;
            else                          exp_addr = rd_addr;
            check_val("mz_addr", mz_addr, exp_addr);
            check_val("mz_din", mz_din, gw ? wr_data : '0);

            // Job ends on the first cycle at/after index 4 with mz idle.
            if (in_job) begin
                if (k >= 4 && !mz_busy) begin
                    in_job   = 1'b0;
                    exp_done = 1'b1;
                    done_cnt++;
                end else begin
                    k++;
                end
            end
            if (gw) begin
                last_wr = 1'b1;
                wr_cnt++;
            end
            if (gz) begin
                last_wr = 1'b0;
                cur     = jobq.pop_front();
                in_job  = 1'b1;
                k       = 0;
            end
            if (req_valid && qsz < QD) begin
                if (req_low > req_high) begin
                    exp_err = 1'b1;
                    err_cnt++;
                end else begin
                    jobq.push_back('{low: req_low, high: req_high});
                    acc_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        rd_addr = AW'($urandom);
    endtask

    task automatic push_req(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        int n = 0;
        req_low   = lo;
        req_high  = hi;
        req_valid = 1'b1;
        while (!req_ready && n < 3000) begin
            tick();
            n++;
        end
        check_val("push_timeout", n < 3000, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
        int n = 0;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        while (!wr_ready && n < 3000) begin
            tick();
            n++;
        end
        check_val("wr_timeout", n < 3000, 1);
        check_val("wr_addr_out", mz_addr, a);
        check_val("wr_din_out", mz_din, d);
        check_val("wr_idle", busy, 0);
        tick();
        wr_valid = 1'b0;
        waited   = n;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((in_job || jobq.size() > 0 || busy) && n < 3000) begin
            tick();
            n++;
        end
        check_val("quiet_timeout", n < 3000, 1);
        tick();
        tick();
    endtask

    int d0, a0, e0, w0, waited, n;
    logic [AW-1:0] lo, hi;

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_low   = '0;
        req_high  = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = 8'h5C;
        #2;
        check_val("rst_mz_addr", mz_addr, 8'h5C);
        check_val("rst_req_ready", req_ready, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Full-range job, latency from handshake.
        d0 = done_cnt;
        push_req(8'h00, 8'hFF);
        tick();
        check_val("lat_ld_high", mz_ld_high, 1);
        check_val("lat_addr_hi", mz_addr, 8'hFF);
        tick();
        check_val("lat_ld_low", mz_ld_low, 1);
        check_val("lat_addr_lo", mz_addr, 8'h00);
        tick();
        check_val("lat_zero", mz_zero, 1);
        wait_quiet();
        check_val("t1_done", done_cnt - d0, 1);
        check_val("t1_qcnt", q_count, 0);

        // Fill the queue behind a running job.
        d0 = done_cnt;
        push_req(8'h00, 8'h3F);
        repeat (3) tick();
        push_req(8'h10, 8'h12);
        push_req(8'h20, 8'h20);
        push_req(8'h30, 8'h35);
        push_req(8'h40, 8'h47);
        check_val("t2_full_qcnt", q_count, 4);
        req_low   = 8'h50;
        req_high  = 8'h51;
        req_valid = 1'b1;
        check_val("t2_fifth_ready", req_ready, 0);
        tick();
        req_valid = 1'b0;
        check_val("t2_qcnt_held", q_count, 4);
        wait_quiet();
        check_val("t2_done", done_cnt - d0, 5);

        // Malformed request.
        e0 = err_cnt;
        push_req(8'h80, 8'h10);
        check_val("t3_err_pulse", req_err, 1);
        check_val("t3_qcnt", q_count, 0);
        tick();
        check_val("t3_no_job", busy, 0);
        check_val("t3_err_cnt", err_cnt - e0, 1);

        // Host write stalls behind a job.
        push_req(8'h00, 8'h1F);
        tick();
        tick();
        host_write(8'h33, 8'h77, waited);
        check_val("t4_stalled", waited > 30, 1);
        wait_quiet();

        // Contention: write held while jobs are queued.
        d0 = done_cnt;
        w0 = wr_cnt;
        push_req(8'h00, 8'h30);
        tick();
        tick();
        push_req(8'h01, 8'h03);
        push_req(8'h04, 8'h09);
        wr_addr  = 8'h5A;
        wr_data  = 8'hA5;
        wr_valid = 1'b1;
        n = 0;
        while ((in_job || jobq.size() > 0) && n < 3000) begin
            tick();
            n++;
        end
        wr_valid = 1'b0;
        check_val("t5_timeout", n < 3000, 1);
        wait_quiet();
        check_val("t5_done", done_cnt - d0, 3);
        check_val("t5_writes", (wr_cnt - w0) >= 2, 1);

        // Reset during WAIT_DONE.
        push_req(8'h00, 8'h3F);
        push_req(8'h02, 8'h04);
        n = 0;
        while (!(in_job && k >= 6) && n < 3000) begin
            tick();
            n++;
        end
        check_val("t6_reach_wait", n < 3000, 1);
        reset = 1'b0;
        #1;
        check_val("t6_busy", busy, 0);
        check_val("t6_qcnt", q_count, 0);
        check_val("t6_done", zero_done, 0);
        check_val("t6_zero", mz_zero, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        d0 = done_cnt;
        push_req(8'h05, 8'h09);
        wait_quiet();
        check_val("t6_after", done_cnt - d0, 1);

        // Random traffic.
        d0 = done_cnt;
        a0 = acc_cnt;
        for (int i = 0; i < 600; i++) begin
            lo = AW'($urandom);
            if (lo > 8'hF0) lo = lo - 8'h10;
            if ($urandom_range(0, 7) == 0) hi = AW'($urandom);
            else                           hi = lo + AW'($urandom_range(0, 5));
            req_low   = lo;
            req_high  = hi;
            req_valid = ($urandom_range(0, 3) == 0);
            wr_valid  = ($urandom_range(0, 2) == 0);
            wr_addr   = AW'($urandom);
            wr_data   = DW'($urandom);
            tick();
        end
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        wait_quiet();
        check_val("rand_jobs_done", done_cnt - d0, acc_cnt - a0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mz_zero_scheduler.md
Name: mz_zero_scheduler

Overview:
- Front-end controller for the memory-zero block (mz); owns mz's single control/address port.
- Queues zero-range requests and sequences each one on mz as ld_high, ld_low, zero, then waits for mz busy to clear.
- Arbitrates the mz port between queued zero jobs and a host write port. A host read address passes through whenever the port is otherwise idle.

Parameters:
- ADDRWIDTH, 8, width of memory address.
- DATAWIDTH, 8, width of memory data.
- QDEPTH, 4, zero-request FIFO depth (power of 2, >=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  zero-range request valid.
- req_ready  out  1  request accepted when req_valid&&req_ready at a rising edge.
- req_low  in  ADDRWIDTH  range start (inclusive).
- req_high  in  ADDRWIDTH  range end (inclusive).
- wr_valid  in  1  host write valid.
- wr_ready  out  1  host write accepted this cycle.
- wr_addr  in  ADDRWIDTH  host write address.
- wr_data  in  DATAWIDTH  host write data.
- rd_addr  in  ADDRWIDTH  host read address, forwarded when the port is idle.
- mz_ld_high  out  1  to mz ld_high.
- mz_ld_low  out  1  to mz ld_low.
- mz_zero  out  1  to mz zero.
- mz_write  out  1  to mz write.
- mz_addr  out  ADDRWIDTH  to mz addr.
- mz_din  out  DATAWIDTH  to mz din.
- mz_busy  in  1  from mz busy.
- busy  out  1  scheduler is executing a zero job (state != IDLE).
- zero_done  out  1  one-cycle pulse when a job completes.
- req_err  out  1  one-cycle pulse when a malformed request (low>high) is accepted and dropped.
- q_count  out  $clog2(QDEPTH)+1  queued request count.

Behaviour:
- Reset (reset==0, asynchronous): FSM=IDLE, FIFO empty, last_grant=ZERO. All outputs 0 except mz_addr=rd_addr (combinational); q_count=0. The same reset also drives mz.
- req_ready = FIFO not full; this is independent of FSM state.
- Request validation at push: if req_low>req_high, the request is accepted but not stored, and req_err pulses the next cycle. req_low==req_high is legal (single address).
- Push and pop in the same cycle are allowed; on a full FIFO, a pop frees the slot only on the next cycle (req_ready has no combinational dependence on pop).
- FSM states: IDLE, LD_HIGH, LD_LOW, START, GUARD, WAIT_DONE.
- IDLE arbitration when both wr_valid and FIFO non-empty: grant opposite of last_grant (round robin); otherwise grant whichever is pending.
  - Write grant: wr_ready=1, mz_write=1, mz_addr=wr_addr, mz_din=wr_data, all combinational in the same cycle; stay in IDLE; last_grant<=WRITE.
  - Zero grant: pop head into job_low/job_high regs; ->LD_HIGH; last_grant<=ZERO.
- LD_HIGH (1 cycle): mz_ld_high=1, mz_addr=job_high. ->LD_LOW.
- LD_LOW (1 cycle): mz_ld_low=1, mz_addr=job_low. ->START.
- START (1 cycle): mz_zero=1. ->GUARD.
- GUARD (1 cycle): mz_busy is ignored, covering mz's busy rise latency. ->WAIT_DONE.
- WAIT_DONE: stay while mz_busy==1. When mz_busy==0, pulse zero_done (registered, asserted the cycle after exit) and ->IDLE.
- wr_ready=0 in every state except IDLE; host writes stall during zeroing and are never dropped.
- Outside IDLE-write, LD_HIGH and LD_LOW: mz_addr=rd_addr and mz_din=0.
- Latency, empty queue with no write contention: handshake at edge N; LD_HIGH in cycle N+2; mz_zero high in cycle N+4; earliest next job LD_HIGH 2 cycles after WAIT_DONE exit.
- Reset mid-job: immediate return to IDLE, queue flushed, no zero_done pulse.

Decomposition:
- Package mz_sched_pkg: state enum (sched_state_t), grant enum (WRITE, ZERO), packed struct zero_req_t {low, high}.
- Sub-module mz_req_fifo: parameterized sync FIFO of zero_req_t with full, empty and count outputs.

Test Plan:
- Single request low=0x00, high=0xFF with mz_busy model high for 256 cycles -> ld_high with addr=FF, ld_low with addr=00, zero in consecutive cycles; busy high throughout; zero_done once; q_count back to 0.
- Push 4 requests back-to-back (QDEPTH=4) while job running -> 5th req_ready=0; all 4 execute in order, 4 zero_done pulses.
- Request low=0x80, high=0x10 -> req_err pulse, q_count unchanged, no mz_ld_high.
- wr_valid held (addr 0x33, data 0x77) during a job -> wr_ready=0 until IDLE, then one mz_write with addr=33, din=77.
- Simultaneous wr_valid and a queued request in IDLE, twice -> grants alternate between write and zero.
- reset=0 asserted during WAIT_DONE -> outputs zero immediately, q_count=0, no zero_done; a new request after release runs normally.
